riscv_fetch_unit: RTL and testbench
===================================

# riscv_fetch_unit

Instruction-fetch and program-counter stage of the single-issue RISC-V core. It holds the PC, fetches one instruction at a time over a req/gnt/rvalid instruction-memory port and presents it to decode with a valid/ready handshake. It consumes the execute stage's `flag_o`/`result_o` outputs to resolve branches, JAL and JALR, and redirects fetch with a flush to decode.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset; must be 4-byte aligned.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; one clock, reset asynchronous and active-low.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  fetch address; equals PC register while `imem_req_o`=1.
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  read data valid; exactly one per grant, at least 1 cycle after it.
- `imem_rdata_i`  in  32  instruction word.
- `instr_valid_o`  out  1  instruction available to decode.
- `instr_ready_i`  in  1  decode accepts the instruction.
- `instr_o`  out  32  instruction word.
- `instr_pc_o`  out  32  address of `instr_o`.
- `ex_valid_i`  in  1  execute stage holds a valid control-transfer instruction.
- `ex_branch_i`, `ex_jal_i`, `ex_jalr_i`  in  1 each  instruction type; one-hot when `ex_valid_i`=1.
- `ex_pc_i`  in  32  PC of the executing instruction.
- `ex_imm_i`  in  32  sign-extended B/J immediate.
- `alu_flag_i`  in  1  ALU comparison flag (branch condition).
- `alu_result_i`  in  32  ALU sum rs1+imm (JALR target).
- `flush_o`  out  1  redirect taken this cycle; decode discards its instruction.
- `trap_o`  out  1  misaligned-target trap (only with `FETCH_MISALIGN_TRAP_EN`).
- `trap_addr_o`  out  32  offending target (only with `FETCH_MISALIGN_TRAP_EN`).

## Operation
- Redirect: `take = ex_valid_i & (ex_jal_i | ex_jalr_i | (ex_branch_i & alu_flag_i))`; `flush_o = take`, combinational.
- Target: JALR → `{alu_result_i[31:1],1'b0}`; else `ex_pc_i + ex_imm_i`, 32-bit wrap-around, carry dropped.
- Sequential PC: `pc_q + 4`, wraps 32'hFFFF_FFFC → 0.
- Registered `drop_q`: marks one outstanding response to discard.
- States:
  - REQ: `imem_req_o`=1. gnt → WAIT, `fetch_pc_q`←`pc_q`, `pc_q`←`pc_q`+4. take → `pc_q`←target; with gnt in the same cycle also `drop_q`←1.
  - WAIT: rvalid & !drop_q → capture `imem_rdata_i` and `fetch_pc_q` → HOLD. rvalid & drop_q → discard, clear `drop_q` → REQ. take without rvalid → `pc_q`←target, `drop_q`←1. take with rvalid → discard data → REQ.
  - HOLD: `instr_valid_o`=1, outputs stable. ready → REQ. take → `pc_q`←target, `instr_valid_o` cleared → REQ. Take wins over simultaneous ready; decode must honour `flush_o`.
  - TRAP: only with macro. No requests, `instr_valid_o`=0; left only by reset.
- `imem_rvalid_i` outside WAIT is ignored.

## Timing
- All outputs are 0 in reset. State REQ, `pc_q`=`RESET_PC`. `imem_req_o` rises in the first cycle after `rst_ni` deasserts.
- Best case with 1-cycle memory: gnt at T, rvalid at T+1, `instr_valid_o` at T+2. Ready at T+2 gives the next request at T+3. Peak rate is one instruction per 3 cycles.
- Redirect latency: target appears on `imem_addr_o` the cycle after `take`, unless a dropped response is pending. In that case it appears the cycle after that response.
- Asynchronous reset mid-fetch abandons the outstanding access; a late rvalid lands in REQ and is ignored.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - take with `target[1]`=1 → `trap_o` pulses 1 cycle, `trap_addr_o`←target (held), state TRAP.
  - A held instruction is dropped; an outstanding response is ignored.
- Not defined: `target[1:0]` forced to 00; `trap_o`/`trap_addr_o` tied to 0; no TRAP state.

## Test plan
- Reset release with `RESET_PC`=0x100, gnt at once, rvalid 1 cycle later, ready always 1 → addresses 0x100, 0x104, 0x108; `instr_pc_o` matches; 3-cycle spacing.
- Taken branch in HOLD: `ex_pc_i`=0x200, `ex_imm_i`=0xFFFFFFF0, `alu_flag_i`=1 → `flush_o`=1, `instr_valid_o` drops, next `imem_addr_o`=0x1F0. Same with `alu_flag_i`=0 → no flush, sequential.
- JALR redirect in WAIT, `alu_result_i`=0x305 → rvalid data discarded, next `imem_addr_o`=0x304; no `instr_valid_o` for the dropped word.
- Redirect coincident with gnt in REQ → dropped response never reaches `instr_o`; target fetched after it.
- Ready held low 5 cycles in HOLD → `instr_o`, `instr_pc_o` stable; `imem_req_o`=0 throughout.
- JAL target 0x402: with macro → `trap_o` pulse, `trap_addr_o`=0x402, no further requests. Without macro → fetch at 0x400. Assert reset mid-WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: PC register and single-outstanding instruction fetch.
// Branches, JAL and JALR from execute redirect fetch and flush decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// redirect to a target with bit 1 set traps and fetch stops until reset.
// When it is undefined, the low two target bits are forced to zero.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        ex_valid_i,
    input  logic        ex_branch_i,
    input  logic        ex_jal_i,
    input  logic        ex_jalr_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_imm_i,
    input  logic        alu_flag_i,
    input  logic [31:0] alu_result_i,
    output logic        flush_o,
    output logic        trap_o,
    output logic [31:0] trap_addr_o
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        drop_q, drop_d;
    logic        take;
    logic [31:0] target_raw;
    logic [31:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] trap_addr_q, trap_addr_d;
`endif

    // Redirect decision and target address, both purely combinational.
    always_comb begin
        take       = ex_valid_i & (ex_jal_i | ex_jalr_i | (ex_branch_i & alu_flag_i));
        target_raw = ex_jalr_i ? (alu_result_i & ~32'h0000_0001) : (ex_pc_i + ex_imm_i);
`ifdef FETCH_MISALIGN_TRAP_EN
        target     = target_raw;
`else
        target     = target_raw & ~32'h0000_0003;
`endif
    end

    // Next-state logic for the fetch FSM, PC and captured instruction.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        drop_d     = drop_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d      = 1'b0;
        trap_addr_d = trap_addr_q;
`endif
        case (state_q)
            S_REQ: begin
                if (imem_gnt_i) begin
                    state_d    = S_WAIT;
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                end
                if (take) begin
                    pc_d = target;
                    if (imem_gnt_i) begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (take) begin
                        pc_d = target;
                    end else if (!drop_q) begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = fetch_pc_q;
                        state_d    = S_HOLD;
                    end
                end else if (take) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (take) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (instr_ready_i) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (take && target_raw[1] && (state_q != S_TRAP)) begin
            state_d     = S_TRAP;
            drop_d      = 1'b0;
            trap_d      = 1'b1;
            trap_addr_d = target_raw;
        end
`endif
    end

    // State registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            fetch_pc_q <= 32'h0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            drop_q     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            drop_q     <= drop_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
`endif
        end
    end

    // Output drive; combinational outputs are forced low while reset is held.
    always_comb begin
        imem_req_o    = (state_q == S_REQ) & rst_ni;
        imem_addr_o   = imem_req_o ? pc_q : 32'h0;
        instr_valid_o = (state_q == S_HOLD);
        instr_o       = instr_q;
        instr_pc_o    = instr_pc_q;
        flush_o       = take & rst_ni;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_o        = trap_q;
        trap_addr_o   = trap_addr_q;
`else
        trap_o        = 1'b0;
        trap_addr_o   = 32'h0;
`endif
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed scenarios for riscv_fetch_unit with RESET_PC=0x100.
module tb_riscv_fetch_unit;

    logic        clk;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        ex_valid_i;
    logic        ex_branch_i;
    logic        ex_jal_i;
    logic        ex_jalr_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_imm_i;
    logic        alu_flag_i;
    logic [31:0] alu_result_i;
    logic        flush_o;
    logic        trap_o;
    logic [31:0] trap_addr_o;

    int tests_run;
    int tests_failed;

    riscv_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .ex_valid_i(ex_valid_i), .ex_branch_i(ex_branch_i), .ex_jal_i(ex_jal_i), .ex_jalr_i(ex_jalr_i),
        .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i), .alu_flag_i(alu_flag_i), .alu_result_i(alu_result_i),
        .flush_o(flush_o), .trap_o(trap_o), .trap_addr_o(trap_addr_o)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid_i   = 1'b0;
        ex_branch_i  = 1'b0;
        ex_jal_i     = 1'b0;
        ex_jalr_i    = 1'b0;
        ex_pc_i      = 32'h0;
        ex_imm_i     = 32'h0;
        alu_flag_i   = 1'b0;
        alu_result_i = 32'h0;
    endtask

    // One grant cycle plus one rvalid cycle; leaves the DUT holding the word.
    task automatic do_fetch(input logic [31:0] exp_addr);
        imem_gnt_i = 1'b1;
        #1;
        tests_run++; if (imem_req_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL fetch_req: got %0b want 1", imem_req_o); end
        tests_run++; if (imem_addr_o !== exp_addr) begin tests_failed++; $display("[TB] FAIL fetch_addr: got %h want %h", imem_addr_o, exp_addr); end
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word_at(exp_addr);
        #1;
        tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL wait_req: got %0b want 0", imem_req_o); end
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        tests_run++; if (instr_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_valid: got %0b want 1", instr_valid_o); end
        tests_run++; if (instr_o !== word_at(exp_addr)) begin tests_failed++; $display("[TB] FAIL hold_instr: got %h want %h", instr_o, word_at(exp_addr)); end
        tests_run++; if (instr_pc_o !== exp_addr) begin tests_failed++; $display("[TB] FAIL hold_pc: got %h want %h", instr_pc_o, exp_addr); end
        tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_req: got %0b want 0", imem_req_o); end
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        instr_ready_i = 1'b0;
        clear_ex();
        ex_valid_i = 1'b1;
        ex_jal_i   = 1'b1;
        tick();
        tick();
        tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_req: got %0b want 0", imem_req_o); end
        tests_run++; if (imem_addr_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_addr: got %h want 0", imem_addr_o); end
        tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_flush: got %0b want 0", flush_o); end
        tests_run++; if (instr_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_valid: got %0b want 0", instr_valid_o); end
        tests_run++; if (instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_instr: got %h/%h want 0/0", instr_o, instr_pc_o); end
        tests_run++; if (trap_o !== 1'b0 || trap_addr_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_trap: got %0b/%h want 0/0", trap_o, trap_addr_o); end
        clear_ex();
        rst_ni = 1'b1;
        #1;
        tests_run++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin tests_failed++; $display("[TB] FAIL rel_req: got %0b/%h want 1/00000100", imem_req_o, imem_addr_o); end
        tick();
    endtask

    task automatic test_sequential();
        instr_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_fetch(32'h100 + 32'(4 * k));
            tick();
        end
    endtask

    task automatic test_branch();
        do_fetch(32'h10C);
        ex_valid_i  = 1'b1;
        ex_branch_i = 1'b1;
        ex_pc_i     = 32'h200;
        ex_imm_i    = 32'hFFFF_FFF0;
        alu_flag_i  = 1'b1;
        #1;
        tests_run++; if (flush_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL br_flush: got %0b want 1", flush_o); end
        tick();
        clear_ex();
        #1;
        tests_run++; if (instr_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL br_valid: got %0b want 0", instr_valid_o); end
        tests_run++; if (imem_addr_o !== 32'h1F0) begin tests_failed++; $display("[TB] FAIL br_target: got %h want 000001f0", imem_addr_o); end
        do_fetch(32'h1F0);
        ex_valid_i  = 1'b1;
        ex_branch_i = 1'b1;
        ex_pc_i     = 32'h200;
        ex_imm_i    = 32'hFFFF_FFF0;
        alu_flag_i  = 1'b0;
        #1;
        tests_run++; if (flush_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL nt_flush: got %0b want 0", flush_o); end
        tick();
        clear_ex();
        #1;
        tests_run++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1F4) begin tests_failed++; $display("[TB] FAIL nt_seq: got %0b/%h want 1/000001f4", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_jalr_wait();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i   = 1'b0;
        ex_valid_i   = 1'b1;
        ex_jalr_i    = 1'b1;
        alu_result_i = 32'h305;
        #1;
        tests_run++; if (flush_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL jalr_flush: got %0b want 1", flush_o); end
        tick();
        clear_ex();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL jalr_wait: got %0b want 0", imem_req_o); end
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        tests_run++; if (instr_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL jalr_drop: got %0b want 0", instr_valid_o); end
        tests_run++; if (imem_addr_o !== 32'h304) begin tests_failed++; $display("[TB] FAIL jalr_target: got %h want 00000304", imem_addr_o); end
        do_fetch(32'h304);
        tick();
    endtask

    task automatic test_back_to_back();
        imem_gnt_i = 1'b1;
        ex_valid_i = 1'b1;
        ex_jal_i   = 1'b1;
        ex_pc_i    = 32'h500;
        ex_imm_i   = 32'h100;
        #1;
        tests_run++; if (imem_addr_o !== 32'h308 || flush_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL gnt_take: got %h/%0b want 00000308/1", imem_addr_o, flush_o); end
        tick();
        imem_gnt_i = 1'b0;
        clear_ex();
        #1;
        tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL drop_pending: got %0b want 0", imem_req_o); end
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        tests_run++; if (instr_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL drop_valid: got %0b want 0", instr_valid_o); end
        tests_run++; if (imem_addr_o !== 32'h600) begin tests_failed++; $display("[TB] FAIL drop_target: got %h want 00000600", imem_addr_o); end
        instr_ready_i = 1'b0;
        do_fetch(32'h600);
    endtask

    task automatic test_hold_stall();
        instr_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++; if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_ctl: got %0b/%0b want 1/0", instr_valid_o, imem_req_o); end
            tests_run++; if (instr_o !== 32'hC0DE_0600 || instr_pc_o !== 32'h600) begin tests_failed++; $display("[TB] FAIL stall_data: got %h/%h want c0de0600/00000600", instr_o, instr_pc_o); end
        end
        instr_ready_i = 1'b1;
        tick();
        tests_run++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h604) begin tests_failed++; $display("[TB] FAIL stall_next: got %0b/%h want 1/00000604", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_misalign();
        ex_valid_i = 1'b1;
        ex_jal_i   = 1'b1;
        ex_pc_i    = 32'h400;
        ex_imm_i   = 32'h2;
        #1;
        tests_run++; if (flush_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL mis_flush: got %0b want 1", flush_o); end
        tick();
        clear_ex();
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        tests_run++; if (trap_o !== 1'b1 || trap_addr_o !== 32'h402) begin tests_failed++; $display("[TB] FAIL trap_pulse: got %0b/%h want 1/00000402", trap_o, trap_addr_o); end
        tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL trap_req: got %0b want 0", imem_req_o); end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        #1;
        tests_run++; if (trap_o !== 1'b0 || trap_addr_o !== 32'h402) begin tests_failed++; $display("[TB] FAIL trap_hold: got %0b/%h want 0/00000402", trap_o, trap_addr_o); end
        tests_run++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL trap_idle: got %0b/%0b want 0/0", imem_req_o, instr_valid_o); end
`else
        tests_run++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h400) begin tests_failed++; $display("[TB] FAIL mis_align: got %0b/%h want 1/00000400", imem_req_o, imem_addr_o); end
        tests_run++; if (trap_o !== 1'b0 || trap_addr_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL mis_trap: got %0b/%h want 0/0", trap_o, trap_addr_o); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        rst_ni     = 1'b0;
        ex_valid_i = 1'b1;
        ex_jal_i   = 1'b1;
        #1;
        tests_run++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL arst_req: got %0b/%h want 0/0", imem_req_o, imem_addr_o); end
        tests_run++; if (instr_valid_o !== 1'b0 || flush_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_ctl: got %0b/%0b want 0/0", instr_valid_o, flush_o); end
        tests_run++; if (instr_o !== 32'h0 || instr_pc_o !== 32'h0 || trap_o !== 1'b0 || trap_addr_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL arst_data: got %h/%h/%0b/%h want zeros", instr_o, instr_pc_o, trap_o, trap_addr_o); end
        tick();
        clear_ex();
        rst_ni        = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD1_BAD1;
        #1;
        tests_run++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin tests_failed++; $display("[TB] FAIL late_req: got %0b/%h want 1/00000100", imem_req_o, imem_addr_o); end
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        tests_run++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin tests_failed++; $display("[TB] FAIL late_ignored: got %0b/%0b/%h want 0/1/00000100", instr_valid_o, imem_req_o, imem_addr_o); end
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_jalr_wait();
        test_back_to_back();
        test_hold_stall();
        test_misalign();
        test_reset_mid_wait();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
